// File: rtl/led_matrix_pwm_scanner.sv
// RGB LED matrix scanner: double-buffered grey-level frame store driving a serial
// row shift chain (3*ROWS bits) and one-hot column drivers with BCM-free PWM slices.
module led_matrix_pwm_scanner #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned BPC     = 2,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DWELL   = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [BPC-1:0]          wr_r,
  input  logic [BPC-1:0]          wr_g,
  input  logic [BPC-1:0]          wr_b,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    frame_start,
  output logic [$clog2(COLS)-1:0] col_num,
  output logic                    reset_out,
  output logic                    OE,
  output logic                    SH_CP,
  output logic                    ST_CP,
  output logic                    DS,
  output logic [COLS-1:0]         col_select
);

  localparam int unsigned CW      = $clog2(COLS);
  localparam int unsigned RW      = $clog2(ROWS);
  localparam int unsigned PW      = 3 * BPC;
  localparam int unsigned NS      = (1 << BPC) - 1;
  localparam int unsigned CNT_MAX = (DWELL > 2 * CLK_DIV) ? DWELL : 2 * CLK_DIV;
  localparam int unsigned NW      = $clog2(CNT_MAX + 1);

  localparam logic [CW:0] COL_LIM = COLS[CW:0];
  localparam logic [RW:0] ROW_LIM = ROWS[RW:0];

  localparam logic [1:0] CLEAR   = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] LATCH   = 2'd2;
  localparam logic [1:0] DISPLAY = 2'd3;

  logic [1:0]     state, state_n;
  logic [NW-1:0]  cnt, cnt_n;
  logic [CW-1:0]  col, col_n;
  logic [BPC-1:0] slice, slice_n;
  logic [1:0]     ch, ch_n;
  logic [RW-1:0]  row, row_n;
  logic           front, front_n;
  logic           back;
  logic           disp_valid, disp_valid_n;
  logic           swap_pending, swap_pending_n;
  logic           frame_end;
  logic           wr_ok;
  logic [PW-1:0]  pix;
  logic [BPC-1:0] level;

  logic                    swap_ack_n, frame_start_n, reset_out_n;
  logic                    oe_n, sh_cp_n, st_cp_n, ds_n;
  logic [COLS-1:0]         col_select_n;

  logic [PW-1:0] mem [2][COLS][ROWS];

  assign back    = ~front;
  assign col_num = col;
  assign wr_ok   = ({1'b0, wr_col} < COL_LIM) && ({1'b0, wr_row} < ROW_LIM);

  // Pixel store: writes always target the bank that is back before this edge
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[back][wr_col][wr_row] <= {wr_r, wr_g, wr_b};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= CLEAR;
      cnt          <= '0;
      col          <= '0;
      slice        <= '0;
      ch           <= '0;
      row          <= '0;
      front        <= 1'b0;
      disp_valid   <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      frame_start  <= 1'b0;
      reset_out    <= 1'b0;
      OE           <= 1'b1;
      SH_CP        <= 1'b0;
      ST_CP        <= 1'b0;
      DS           <= 1'b0;
      col_select   <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      col          <= col_n;
      slice        <= slice_n;
      ch           <= ch_n;
      row          <= row_n;
      front        <= front_n;
      disp_valid   <= disp_valid_n;
      swap_pending <= swap_pending_n;
      swap_ack     <= swap_ack_n;
      frame_start  <= frame_start_n;
      reset_out    <= reset_out_n;
      OE           <= oe_n;
      SH_CP        <= sh_cp_n;
      ST_CP        <= st_cp_n;
      DS           <= ds_n;
      col_select   <= col_select_n;
    end
  end

  // Next state, swap bookkeeping, and pin values derived from the next state
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + NW'(1);
    col_n     = col;
    slice_n   = slice;
    ch_n      = ch;
    row_n     = row;
    frame_end = 1'b0;

    case (state)
      CLEAR: begin
        if (cnt == NW'(CLK_DIV - 1)) begin
          state_n = SHIFT;
          cnt_n   = '0;
          col_n   = '0;
          slice_n = '0;
          ch_n    = '0;
          row_n   = RW'(ROWS - 1);
        end
      end
      SHIFT: begin
        if (cnt == NW'(2 * CLK_DIV - 1)) begin
          cnt_n = '0;
          if (row == '0) begin
            if (ch == 2'd2) begin
              state_n = LATCH;
            end else begin
              ch_n  = ch + 2'd1;
              row_n = RW'(ROWS - 1);
            end
          end else begin
            row_n = row - RW'(1);
          end
        end
      end
      LATCH: begin
        if (cnt == NW'(CLK_DIV - 1)) begin
          state_n = DISPLAY;
          cnt_n   = '0;
        end
      end
      default: begin
        if (cnt == NW'(DWELL - 1)) begin
          state_n = SHIFT;
          cnt_n   = '0;
          ch_n    = '0;
          row_n   = RW'(ROWS - 1);
          if (slice == BPC'(NS - 1)) begin
            slice_n = '0;
            if (col == CW'(COLS - 1)) begin
              col_n     = '0;
              frame_end = 1'b1;
            end else begin
              col_n = col + CW'(1);
            end
          end else begin
            slice_n = slice + BPC'(1);
          end
        end
      end
    endcase

    front_n        = front;
    disp_valid_n   = disp_valid;
    swap_pending_n = swap_pending | swap_req;
    swap_ack_n     = 1'b0;
    if (frame_end && swap_pending_n) begin
      front_n        = ~front;
      disp_valid_n   = 1'b1;
      swap_pending_n = 1'b0;
      swap_ack_n     = 1'b1;
    end

    // A write on the swap edge lands in the new front bank; forward it to the first bit
    pix = mem[front_n][col_n][row_n];
    if (wr_en && wr_ok && (back == front_n) && (wr_col == col_n) && (wr_row == row_n)) begin
      pix = {wr_r, wr_g, wr_b};
    end
    case (ch_n)
      2'd0:    level = pix[PW-1 -: BPC];
      2'd1:    level = pix[2*BPC-1 -: BPC];
      default: level = pix[BPC-1:0];
    endcase

    reset_out_n   = (state_n != CLEAR);
    oe_n          = (state_n != DISPLAY);
    sh_cp_n       = (state_n == SHIFT) && (cnt_n >= NW'(CLK_DIV));
    st_cp_n       = (state_n == LATCH);
    ds_n          = (state_n == SHIFT) && disp_valid_n && (level > slice_n);
    col_select_n  = (state_n == DISPLAY) ? (COLS'(1) << col_n) : '0;
    frame_start_n = (state_n == SHIFT) && (state != SHIFT) && (col_n == '0) && (slice_n == '0);
  end

endmodule
